aurora_rx_block_parser: RTL and testbench

Consumes the 66-bit block stream from `aurora_rx_lane` (`rx_data_o`, `rx_header_o`, `rx_valid_o`) on the lane's `clk_rx_i` domain. Classifies each block as data, idle, user-K or error, and forwards only payload. Runs a lane-up state machine with header-error rate and valid-gap watchdogs. Feeds the channel/bonding logic above the lane.

---
 rtl/aurora_pkg.sv | 38 +++
 rtl/aurora_sat_counter.sv | 21 ++
 rtl/aurora_rx_block_parser.sv | 173 +++++++++++++++++
 tb/tb_aurora_rx_block_parser.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared constants, enums and block classifier for the Aurora receive block parser.
package aurora_pkg;

   localparam logic [1:0] HDR_DATA     = 2'b01;
   localparam logic [1:0] HDR_CTRL     = 2'b10;
   localparam logic [7:0] BT_IDLE      = 8'h78;
   localparam logic [7:0] BT_USERK_MIN = 8'hD2;
   localparam logic [7:0] BT_USERK_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_DOWN = 2'd0,
      ST_SYNC = 2'd1,
      ST_UP   = 2'd2
   } lane_state_t;

   typedef enum logic [1:0] {
      BLK_DATA  = 2'd0,
      BLK_IDLE  = 2'd1,
      BLK_USERK = 2'd2,
      BLK_BAD   = 2'd3
   } blk_class_t;

   function automatic blk_class_t classify(input logic [1:0] hdr, input logic [7:0] btype);
      blk_class_t c;
      c = BLK_BAD;
      if (hdr == HDR_DATA) begin
         c = BLK_DATA;
      end else if (hdr == HDR_CTRL) begin
         if (btype == BT_IDLE)
            c = BLK_IDLE;
         // widened compare so the upper bound stays meaningful if the range ever shrinks
         else if (btype >= BT_USERK_MIN && {1'b0, btype} <= {1'b0, BT_USERK_MAX})
            c = BLK_USERK;
      end
      return c;
   endfunction

endpackage

// File: rtl/aurora_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module aurora_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/aurora_rx_block_parser.sv
// Aurora 64b/66b receive block parser: classify, forward payload, lane-up FSM with watchdogs.
// Optional statistics counters enabled by AURORA_RX_PARSER_STATS_EN.
//
// state   | meaning
// DOWN    | no lock; waiting for first good block
// SYNC    | counting consecutive good blocks toward LOCK_CNT
// UP      | lane up; payload forwarded, error-rate and gap watchdogs armed
module aurora_rx_block_parser
   import aurora_pkg::*;
#(
   parameter int LOCK_CNT   = 32,
   parameter int ERR_MAX    = 16,
   parameter int ERR_WINDOW = 1024,
   parameter int TIMEOUT    = 256
) (
   input  logic        clk_rx_i,
   input  logic        rst_i,
   input  logic [63:0] rx_data_i,
   input  logic [1:0]  rx_header_i,
   input  logic        rx_valid_i,
   output logic [63:0] data_o,
   output logic        data_valid_o,
   output logic [55:0] user_k_o,
   output logic [7:0]  user_k_type_o,
   output logic        user_k_valid_o,
   output logic        lane_up_o,
   output logic        hdr_err_o
`ifdef AURORA_RX_PARSER_STATS_EN
   ,
   output logic [31:0] blk_cnt_o,
   output logic [31:0] err_cnt_o
`endif
);

   localparam int LOCK_W = $clog2(LOCK_CNT) + 1;
   localparam int ERR_W  = $clog2(ERR_MAX) + 1;
   localparam int WIN_W  = $clog2(ERR_WINDOW) + 1;
   localparam int GAP_W  = $clog2(TIMEOUT) + 1;

   lane_state_t       state, state_n;
   logic [LOCK_W-1:0] lock_cnt, lock_cnt_n;
   logic [ERR_W-1:0]  err_cnt, err_cnt_n, err_sum;
   logic [WIN_W-1:0]  win_cnt, win_cnt_n, win_sum;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;

   blk_class_t cls;
   logic       is_bad, is_good, gap_hit, fwd_data, fwd_userk;

   always_comb begin
      cls       = classify(rx_header_i, rx_data_i[63:56]);
      is_bad    = rx_valid_i && (cls == BLK_BAD);
      is_good   = rx_valid_i && (cls != BLK_BAD);
      gap_hit   = (state != ST_DOWN) && !rx_valid_i && (gap_cnt == GAP_W'(TIMEOUT - 1));
      fwd_data  = rx_valid_i && (state == ST_UP) && (cls == BLK_DATA);
      fwd_userk = rx_valid_i && (state == ST_UP) && (cls == BLK_USERK);
   end

   always_comb begin
      state_n    = state;
      lock_cnt_n = lock_cnt;
      err_cnt_n  = err_cnt;
      win_cnt_n  = win_cnt;
      gap_cnt_n  = (state == ST_DOWN || rx_valid_i) ? '0 : gap_cnt + GAP_W'(1);
      win_sum    = win_cnt + WIN_W'(1);
      err_sum    = err_cnt + ERR_W'(is_bad);

      case (state)
         ST_DOWN: begin
            lock_cnt_n = '0;
            if (is_good) begin
               state_n    = ST_SYNC;
               lock_cnt_n = LOCK_W'(1);
            end
         end
         ST_SYNC: begin
            if (gap_hit || is_bad) begin
               state_n = ST_DOWN;
            end else if (is_good) begin
               if (lock_cnt == LOCK_W'(LOCK_CNT - 1)) begin
                  state_n    = ST_UP;
                  lock_cnt_n = '0;
                  win_cnt_n  = '0;
                  err_cnt_n  = '0;
               end else begin
                  lock_cnt_n = lock_cnt + LOCK_W'(1);
               end
            end
         end
         ST_UP: begin
            if (rx_valid_i) begin
               // threshold is checked before the window wraps, so the closing block's error counts
               if (err_sum == ERR_W'(ERR_MAX)) begin
                  state_n = ST_DOWN;
               end else if (win_sum == WIN_W'(ERR_WINDOW)) begin
                  win_cnt_n = '0;
                  err_cnt_n = '0;
               end else begin
                  win_cnt_n = win_sum;
                  err_cnt_n = err_sum;
               end
            end else if (gap_hit) begin
               state_n = ST_DOWN;
            end
         end
         default: state_n = ST_DOWN;
      endcase

      if (state_n == ST_DOWN) begin
         lock_cnt_n = (state == ST_DOWN) ? lock_cnt_n : '0;
         err_cnt_n  = '0;
         win_cnt_n  = '0;
         gap_cnt_n  = '0;
      end
   end

   always_ff @(posedge clk_rx_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_DOWN;
         lock_cnt <= '0;
         err_cnt  <= '0;
         win_cnt  <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_n;
         lock_cnt <= lock_cnt_n;
         err_cnt  <= err_cnt_n;
         win_cnt  <= win_cnt_n;
         gap_cnt  <= gap_cnt_n;
      end
   end

   always_ff @(posedge clk_rx_i or posedge rst_i) begin
      if (rst_i) begin
         data_o         <= '0;
         data_valid_o   <= 1'b0;
         user_k_o       <= '0;
         user_k_type_o  <= '0;
         user_k_valid_o <= 1'b0;
         lane_up_o      <= 1'b0;
         hdr_err_o      <= 1'b0;
      end else begin
         data_valid_o   <= fwd_data;
         user_k_valid_o <= fwd_userk;
         hdr_err_o      <= is_bad;
         lane_up_o      <= (state_n == ST_UP);
         if (fwd_data)
            data_o <= rx_data_i;
         if (fwd_userk) begin
            user_k_o      <= rx_data_i[55:0];
            user_k_type_o <= rx_data_i[63:56];
         end
      end
   end

`ifdef AURORA_RX_PARSER_STATS_EN
   aurora_sat_counter #(.W(32)) u_blk_cnt (
      .clk   (clk_rx_i),
      .rst   (rst_i),
      .inc   (rx_valid_i),
      .clr   (1'b0),
      .count (blk_cnt_o)
   );

   aurora_sat_counter #(.W(32)) u_err_cnt (
      .clk   (clk_rx_i),
      .rst   (rst_i),
      .inc   (is_bad),
      .clr   (1'b0),
      .count (err_cnt_o)
   );
`endif

endmodule

// File: tb/tb_aurora_rx_block_parser.sv
// Directed bench for aurora_rx_block_parser; stats checks follow AURORA_RX_PARSER_STATS_EN.
module tb_aurora_rx_block_parser;

   logic        clk_rx_i = 1'b0;
   logic        rst_i    = 1'b1;
   logic [63:0] rx_data_i   = '0;
   logic [1:0]  rx_header_i = '0;
   logic        rx_valid_i  = 1'b0;
   logic [63:0] data_o;
   logic        data_valid_o;
   logic [55:0] user_k_o;
   logic [7:0]  user_k_type_o;
   logic        user_k_valid_o;
   logic        lane_up_o;
   logic        hdr_err_o;
`ifdef AURORA_RX_PARSER_STATS_EN
   logic [31:0] blk_cnt_o;
   logic [31:0] err_cnt_o;
`endif

   int vecs = 0;
   int miscompares = 0;
   int herr_seen = 0;

   aurora_rx_block_parser dut (
      .clk_rx_i       (clk_rx_i),
      .rst_i          (rst_i),
      .rx_data_i      (rx_data_i),
      .rx_header_i    (rx_header_i),
      .rx_valid_i     (rx_valid_i),
      .data_o         (data_o),
      .data_valid_o   (data_valid_o),
      .user_k_o       (user_k_o),
      .user_k_type_o  (user_k_type_o),
      .user_k_valid_o (user_k_valid_o),
      .lane_up_o      (lane_up_o),
      .hdr_err_o      (hdr_err_o)
`ifdef AURORA_RX_PARSER_STATS_EN
      ,
      .blk_cnt_o      (blk_cnt_o),
      .err_cnt_o      (err_cnt_o)
`endif
   );

   always #5 clk_rx_i = ~clk_rx_i;

   function automatic logic [63:0] pl(input int c);
      logic [31:0] w;
      w = c;
      return {w, w};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive one cycle; outputs for this cycle's sample are visible on return
   task automatic tick(input logic v, input logic [1:0] h, input logic [63:0] d);
      rx_valid_i  = v;
      rx_header_i = h;
      rx_data_i   = d;
      @(posedge clk_rx_i);
      #1;
      rx_valid_i = 1'b0;
      if (hdr_err_o) herr_seen++;
   endtask

   task automatic lock_up(input string tag);
      for (int i = 0; i < 31; i++) tick(1'b1, 2'b01, pl(i));
      chk({tag, "_up_after31"}, 64'(lane_up_o), 64'd0);
      chk({tag, "_no_fwd_sync"}, 64'(data_valid_o), 64'd0);
      tick(1'b1, 2'b01, pl(31));
      chk({tag, "_up_after32"}, 64'(lane_up_o), 64'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk_rx_i);
      #1;
      chk("rst_lane_up", 64'(lane_up_o), 64'd0);
      chk("rst_data_valid", 64'(data_valid_o), 64'd0);
      chk("rst_data", data_o, 64'd0);
      chk("rst_userk", {user_k_type_o, user_k_o}, 64'd0);
      rst_i = 1'b0;

      // lock-up and first forwarded block
      lock_up("lock");
      tick(1'b1, 2'b01, pl(32));
      chk("blk33_valid", 64'(data_valid_o), 64'd1);
      chk("blk33_data", data_o, 64'h0000_0020_0000_0020);

      // control decode in UP
      tick(1'b1, 2'b10, 64'h7800_0000_0000_0000);
      chk("idle_no_data", 64'(data_valid_o), 64'd0);
      chk("idle_no_userk", 64'(user_k_valid_o), 64'd0);
      chk("idle_no_err", 64'(hdr_err_o), 64'd0);
      tick(1'b1, 2'b10, 64'hD211_2233_4455_6677);
      chk("userk_valid", 64'(user_k_valid_o), 64'd1);
      chk("userk_type", 64'(user_k_type_o), 64'hD2);
      chk("userk_data", 64'(user_k_o), 64'h0011_2233_4455_6677);
      chk("userk_no_data", 64'(data_valid_o), 64'd0);
      tick(1'b1, 2'b10, 64'h4B00_0000_0000_0000);
      chk("bt4b_err", 64'(hdr_err_o), 64'd1);
      chk("bt4b_no_userk", 64'(user_k_valid_o), 64'd0);
      chk("bt4b_still_up", 64'(lane_up_o), 64'd1);

      // timeout: 255 idle cycles survive, 256 take the lane down
      repeat (255) tick(1'b0, 2'b00, 64'd0);
      chk("gap255_up", 64'(lane_up_o), 64'd1);
      tick(1'b1, 2'b01, 64'hABCD);
      chk("gap255_block_up", 64'(lane_up_o), 64'd1);
      chk("gap255_block_fwd", data_o, 64'hABCD);
      repeat (255) tick(1'b0, 2'b00, 64'd0);
      chk("gap_pre_timeout", 64'(lane_up_o), 64'd1);
      tick(1'b0, 2'b00, 64'd0);
      chk("gap_timeout_down", 64'(lane_up_o), 64'd0);

      // SYNC abort
      herr_seen = 0;
      for (int i = 0; i < 20; i++) tick(1'b1, 2'b01, pl(i));
      tick(1'b1, 2'b00, 64'd0);
      chk("abort_err_pulse", 64'(hdr_err_o), 64'd1);
      lock_up("abort");
      chk("abort_err_count", 64'(herr_seen), 64'd1);

      // error rate: 15 bad blocks in 1000 keep the lane up, the 16th drops it
      herr_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i < 750 && (i % 50) == 7) tick(1'b1, 2'b11, 64'd0);
         else tick(1'b1, 2'b01, pl(i));
      end
      chk("rate15_up", 64'(lane_up_o), 64'd1);
      chk("rate15_pulses", 64'(herr_seen), 64'd15);
      tick(1'b1, 2'b11, 64'd0);
      chk("rate16_down", 64'(lane_up_o), 64'd0);
      chk("rate16_no_fwd", 64'(data_valid_o), 64'd0);

      // window wrap: 15 errors ending exactly on block 1024 are forgotten
      lock_up("win");
      for (int i = 0; i < 1024; i++) begin
         if (i >= 1009) tick(1'b1, 2'b11, 64'd0);
         else tick(1'b1, 2'b01, pl(i));
      end
      chk("win_end_up", 64'(lane_up_o), 64'd1);
      for (int i = 0; i < 15; i++) tick(1'b1, 2'b00, 64'd0);
      chk("win2_15_up", 64'(lane_up_o), 64'd1);
      tick(1'b1, 2'b01, 64'h5A5A);
      tick(1'b1, 2'b11, 64'd0);
      chk("win2_16_down", 64'(lane_up_o), 64'd0);

      // reset mid-stream
      rst_i = 1'b1;
      @(posedge clk_rx_i);
      #1;
      rst_i = 1'b0;
      lock_up("pre");
      for (int i = 0; i < 468; i++) tick(1'b1, 2'b01, pl(i + 100));
`ifdef AURORA_RX_PARSER_STATS_EN
      chk("stats_blk500", 64'(blk_cnt_o), 64'd500);
      chk("stats_err0", 64'(err_cnt_o), 64'd0);
`endif
      chk("pre_rst_valid", 64'(data_valid_o), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrst_lane_up", 64'(lane_up_o), 64'd0);
      chk("midrst_valid", 64'(data_valid_o), 64'd0);
      chk("midrst_data", data_o, 64'd0);
`ifdef AURORA_RX_PARSER_STATS_EN
      chk("midrst_blk", 64'(blk_cnt_o), 64'd0);
`endif
      repeat (2) @(posedge clk_rx_i);
      #1;
      rst_i = 1'b0;
      lock_up("relock");
`ifdef AURORA_RX_PARSER_STATS_EN
      chk("relock_blk32", 64'(blk_cnt_o), 64'd32);
      tick(1'b1, 2'b00, 64'd0);
      chk("relock_err1", 64'(err_cnt_o), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
